fxp_mul_seq: RTL and testbench
==============================

FXP_MUL_SEQ -- requirements
Module: fxp_mul_seq

Interface
REQ-001 SHALL have parameter A_W, default 12: signed multiplicand width.
REQ-002 SHALL have parameter A_F_W, default 8: fractional bits of a.
REQ-003 SHALL have parameter B_W, default 12: signed multiplier width; also the iteration count.
REQ-004 SHALL have parameter B_F_W, default 8: fractional bits of b.
REQ-005 SHALL have parameters O_I_W, default 4, and O_F_W, default 8: output integer and fraction bits; O_W = O_I_W + O_F_W; A_F_W + B_F_W >= O_F_W.
REQ-006 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1: a/b operands valid.
REQ-009 SHALL have port in_ready, output, 1: operands accepted this cycle when in_valid also high.
REQ-010 SHALL have port a, input, A_W: signed fixed-point multiplicand.
REQ-011 SHALL have port b, input, B_W: signed fixed-point multiplier.
REQ-012 SHALL have port out_valid, output, 1: o holds a completed product.
REQ-013 SHALL have port out_ready, input, 1: consumer takes o when out_valid also high.
REQ-014 SHALL have port o, output, O_W: signed fixed-point product, registered.

Function
REQ-015 SHALL implement FSM IDLE -> MUL -> NORM -> DONE -> IDLE; one operation in flight at a time.
REQ-016 SHALL drive in_ready high only in IDLE; on in_valid && in_ready, capture |a|, |b| (A_W/B_W-bit unsigned, so -2^(W-1) is exact), sign = a[MSB] ^ b[MSB], clear accumulator, enter MUL.
REQ-017 SHALL, in MUL, perform one radix-2 shift-add step per cycle over B_W cycles into an (A_W+B_W)-bit unsigned accumulator, then enter NORM.
REQ-018 SHALL, in NORM, shift magnitude right by A_F_W + B_F_W - O_F_W (truncation toward zero), saturate, apply sign, register o, enter DONE.
REQ-019 SHALL saturate: magnitude > 2^(O_W-1)-1 and sign=0 -> o = 0 followed by O_W-1 ones; sign=1 -> o = 1, O_W-2 zeros, 1 (symmetric -(2^(O_W-1)-1)).
REQ-020 SHALL output 0 (never negative zero pattern issues) when the shifted magnitude is 0, regardless of sign.
REQ-021 SHALL assert out_valid exactly in DONE; latency from accepting edge k to out_valid high is B_W+1 edges (13 at defaults).
REQ-022 SHALL hold o and out_valid stable while out_valid && !out_ready; on out_ready return to IDLE the next edge, in_ready high that cycle.
REQ-023 SHALL ignore a, b, in_valid outside IDLE; o retains last result after handshake until next NORM.

Reset
REQ-024 SHALL, on rst high at a clock edge, enter IDLE, clear accumulator, drive o = 0, out_valid = 0, in_ready = 1 the following cycle.
REQ-025 SHALL abort any operation mid-MUL/NORM/DONE on rst with no result produced; rst dominates simultaneous in_valid.

Configuration
REQ-026 SHALL, with macro FXP_MUL_ROUND_EN defined, add 2^(shift-1) to the magnitude before the NORM shift (round half away from zero), only if shift > 0; without it, plain truncation per REQ-018; saturation applied after rounding in both cases.

Verification
REQ-027 SHALL cover: a=0x180 (1.5), b=0x200 (2.0) -> o=0x300, out_valid 13 edges after acceptance.
REQ-028 SHALL cover: a=0xE80 (-1.5), b=0x200 -> o=0xD00 (-3.0).
REQ-029 SHALL cover: a=0x7FF, b=0x7FF -> o=0x7FF; a=0x800 (-8.0), b=0x100 (1.0) -> o=0x801.
REQ-030 SHALL cover: a=0x001, b=0x080 -> o=0x000 without FXP_MUL_ROUND_EN, o=0x001 with it.
REQ-031 SHALL cover: out_ready low 5 cycles in DONE -> o, out_valid stable, in_ready low, new in_valid ignored; result taken on out_ready.
REQ-032 SHALL cover: rst pulsed at MUL cycle 5 -> next cycle in_ready=1, out_valid=0, o=0; following operation correct.

Source files
------------

// File: rtl/fxp_mul_seq.sv
// Sequential signed fixed-point multiplier: sign-magnitude radix-2 shift-add, then normalize/saturate.
// Optional macro FXP_MUL_ROUND_EN: round half away from zero before the normalizing shift.
module fxp_mul_seq #(
    parameter int unsigned A_W   = 12,
    parameter int unsigned A_F_W = 8,
    parameter int unsigned B_W   = 12,
    parameter int unsigned B_F_W = 8,
    parameter int unsigned O_I_W = 4,
    parameter int unsigned O_F_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [A_W-1:0]           a,
    input  logic [B_W-1:0]           b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [O_I_W+O_F_W-1:0]   o
);

    localparam int unsigned O_W    = O_I_W + O_F_W;
    localparam int unsigned P_W    = A_W + B_W;
    localparam int unsigned SHIFT  = A_F_W + B_F_W - O_F_W;
    localparam int unsigned CNT_W  = $clog2(B_W + 1);
    localparam int unsigned O_MAX  = (2 ** (O_W - 1)) - 1;
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
`ifdef FXP_MUL_ROUND_EN
    localparam logic [P_W:0] RND_ADD = (SHIFT > 0) ? ((P_W + 1)'(1) << RND_SH) : '0;
`else
    localparam logic [P_W:0] RND_ADD = '0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [P_W-1:0]   acc;
    logic [P_W-1:0]   a_sh;
    logic [B_W-1:0]   b_sh;
    logic             sign;

    logic [A_W-1:0]   a_mag_c;
    logic [B_W-1:0]   b_mag_c;
    logic             accept_c;
    logic             last_c;
    logic [P_W:0]     mag_rnd_c;
    logic [P_W:0]     mag_sh_c;
    logic [O_W-1:0]   o_c;

    // Operand magnitudes; the most negative value maps to its exact unsigned magnitude
    always_comb begin
        a_mag_c  = a[A_W-1] ? (~a + A_W'(1)) : a;
        b_mag_c  = b[B_W-1] ? (~b + B_W'(1)) : b;
        accept_c = (state == IDLE) && in_valid;
        last_c   = (cnt == CNT_W'(B_W - 1));
    end

    // Normalize, saturate symmetrically, then apply sign (zero magnitude yields plain zero)
    always_comb begin
        mag_rnd_c = {1'b0, acc} + RND_ADD;
        mag_sh_c  = mag_rnd_c >> SHIFT;
        if (mag_sh_c > (P_W + 1)'(O_MAX)) begin
            o_c = sign ? -O_W'(O_MAX) : O_W'(O_MAX);
        end else begin
            o_c = sign ? -O_W'(mag_sh_c) : O_W'(mag_sh_c);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = MUL;
            MUL:     if (last_c) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            o         <= '0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sign      <= 1'b0;
            cnt       <= '0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        a_sh <= P_W'(a_mag_c);
                        b_sh <= b_mag_c;
                        sign <= a[A_W-1] ^ b[B_W-1];
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                MUL: begin
                    if (b_sh[0]) acc <= acc + a_sh;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                end
                NORM:    o <= o_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Bench for fxp_mul_seq: cycle-level handshake model plus arithmetic reference, directed and random phases.
module tb_fxp_mul_seq;

    localparam int unsigned A_W   = 12;
    localparam int unsigned A_F_W = 8;
    localparam int unsigned B_W   = 12;
    localparam int unsigned B_F_W = 8;
    localparam int unsigned O_I_W = 4;
    localparam int unsigned O_F_W = 8;
    localparam int unsigned O_W   = O_I_W + O_F_W;
    localparam int unsigned LAT   = B_W + 1;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           out_valid;
    logic           out_ready;
    logic [O_W-1:0] o;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    fxp_mul_seq #(
        .A_W(A_W), .A_F_W(A_F_W), .B_W(B_W), .B_F_W(B_F_W), .O_I_W(O_I_W), .O_F_W(O_F_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .o(o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product from plain signed arithmetic
    function automatic logic [O_W-1:0] ref_mul(input logic [A_W-1:0] x, input logic [B_W-1:0] y);
        longint p;
        longint mag;
        longint mx;
        int     sh;
        p   = longint'($signed(x)) * longint'($signed(y));
        mag = (p < 0) ? -p : p;
        sh  = A_F_W + B_F_W - O_F_W;
`ifdef FXP_MUL_ROUND_EN
        if (sh > 0) mag = mag + (64'sd1 <<< (sh - 1));
`endif
        mag = mag >>> sh;
        mx  = (64'sd1 <<< (O_W - 1)) - 1;
        if (mag > mx) mag = mx;
        return (p < 0) ? O_W'(-mag) : O_W'(mag);
    endfunction

    // Handshake-level model: busy countdown from acceptance to result
    logic           m_ready;
    logic           m_valid;
    logic [O_W-1:0] m_o;
    logic [O_W-1:0] m_pend;
    int             m_cnt;
    int             m_done;

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_o     <= '0;
            m_cnt   <= 0;
        end else if (m_ready && in_valid) begin
            m_ready <= 1'b0;
            m_cnt   <= LAT;
            m_pend  <= ref_mul(a, b);
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_o     <= m_pend;
                m_done  <= m_done + 1;
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (in_ready !== m_ready || out_valid !== m_valid || o !== m_o) begin
                n_errors++;
                $display("FAIL cycle_cmp t=%0t: in_ready=%b out_valid=%b o=%h, want %b %b %h",
                         $time, in_ready, out_valid, o, m_ready, m_valid, m_o);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        check("wait_in_ready", 32'(in_ready), 32'd1);
    endtask

    // One directed operation with a literal expected result and optional back-pressure
    task automatic run_op(input string name, input logic [A_W-1:0] x, input logic [B_W-1:0] y,
                          input logic [O_W-1:0] want, input int hold);
        int lat;
        logic [O_W-1:0] held;
        wait_ready();
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            a = A_W'($urandom); b = B_W'($urandom); in_valid = 1'($urandom);
            step();
            lat++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(LAT));
        check({name, "_o"}, 32'(o), 32'(want));
        check({name, "_model_pin"}, 32'(ref_mul(x, y)), 32'(want));
        held = o;
        for (int i = 0; i < hold; i++) begin
            a = A_W'($urandom); b = B_W'($urandom); in_valid = 1'b1;
            step();
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_o"}, 32'(o), 32'(held));
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_return_idle"}, 32'(in_ready), 32'd1);
        check({name, "_o_retained"}, 32'(o), 32'(held));
    endtask

    initial begin
        logic [O_W-1:0] r030;
`ifdef FXP_MUL_ROUND_EN
        r030 = 12'h001;
`else
        r030 = 12'h000;
`endif
        m_done = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_o", 32'(o), 32'd0);

        run_op("p1_5x2", 12'h180, 12'h200, 12'h300, 0);
        run_op("m1_5x2", 12'hE80, 12'h200, 12'hD00, 0);
        run_op("sat_pos", 12'h7FF, 12'h7FF, 12'h7FF, 0);
        run_op("sat_neg", 12'h800, 12'h100, 12'h801, 0);
        run_op("tiny", 12'h001, 12'h080, r030, 0);
        run_op("neg_zero", 12'hFFF, 12'h001, 12'h000, 0);
        run_op("backpressure", 12'h100, 12'hF00, 12'hF00, 5);

        // Reset in the middle of MUL, with in_valid asserted alongside reset
        wait_ready();
        a = 12'h180; b = 12'h200; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_o", 32'(o), 32'd0);
        run_op("after_rst", 12'h200, 12'hE00, 12'hC00, 2);

        // Random phase: random operands, handshakes, corner operands and rare resets
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 12'h800;
                1:       a = 12'h7FF;
                2:       a = 12'h000;
                default: a = A_W'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = 12'h800;
                1:       b = 12'h7FF;
                2:       b = B_W'($urandom_range(0, 3));
                default: b = B_W'($urandom);
            endcase
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (m_done < 50) begin
            n_errors++;
            $display("FAIL random_progress: completed %0d, want at least 50", m_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
